// File: rtl/otter_pipe_pkg.sv
// Shared types and constants for the OTTER pipeline sequencer.
package otter_pipe_pkg;

  // Sequencer states: NOP priming, normal flow, data-memory wait, fatal halt.
  typedef enum logic [1:0] {
    StPrime   = 2'd0,
    StRun     = 2'd1,
    StMemWait = 2'd2,
    StHalt    = 2'd3
  } state_e;

  // Canonical RISC-V NOP (addi x0, x0, 0) loaded by the setnull controls.
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  // ALU operand source selects.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

endpackage

// File: rtl/fwd_unit.sv
// Combinational EX-stage forwarding selects and ID-stage write-back bypass.
module fwd_unit
  import otter_pipe_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] ex_rs1,
  input  logic [REG_ADDR_W-1:0] ex_rs2,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  mem_reg_write,
  input  logic                  wb_reg_write,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  id_byp_a,
  output logic                  id_byp_b
);

  logic mem_live;
  logic wb_live;

  // x0 is hardwired zero, so a write to it never produces a usable value.
  assign mem_live = mem_reg_write && (mem_rd != '0);
  assign wb_live  = wb_reg_write && (wb_rd != '0);

  // EX/MEM holds the younger result, so it takes priority over MEM/WB.
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (mem_live && (mem_rd == ex_rs1)) begin
      fwd_a = FWD_MEM;
    end else if (wb_live && (wb_rd == ex_rs1)) begin
      fwd_a = FWD_WB;
    end
    if (mem_live && (mem_rd == ex_rs2)) begin
      fwd_b = FWD_MEM;
    end else if (wb_live && (wb_rd == ex_rs2)) begin
      fwd_b = FWD_WB;
    end
  end

  // Register file writes on the clock edge; bypass covers same-cycle read-after-write.
  always_comb begin
    id_byp_a = wb_live && (wb_rd == id_rs1);
    id_byp_b = wb_live && (wb_rd == id_rs2);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: stage enables/flushes, hazard detection, memory-wait
// freeze with timeout, and saturating stall/flush statistics.
module hazard_ctrl
  import otter_pipe_pkg::*;
#(
  parameter int unsigned REG_ADDR_W   = 5,
  parameter int unsigned PRIME_CYCLES = 4,
  parameter int unsigned WAIT_TIMEOUT = 255,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] ex_rs1,
  input  logic [REG_ADDR_W-1:0] ex_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  mem_reg_write,
  input  logic                  wb_reg_write,
  input  logic                  branch_taken,
  input  logic                  mem_busy,
  output logic                  pc_en,
  output logic                  ifid_en,
  output logic                  idex_en,
  output logic                  exmem_en,
  output logic                  memwb_en,
  output logic                  ifid_setnull,
  output logic                  idex_setnull,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  id_byp_a,
  output logic                  id_byp_b,
  output logic                  timeout_err,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam int unsigned PrimeW = (PRIME_CYCLES > 2) ? $clog2(PRIME_CYCLES) : 1;
  localparam int unsigned WaitW  = $clog2(WAIT_TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [PrimeW-1:0] prime_cnt_q, prime_cnt_d;
  logic [WaitW-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              timeout_err_q, timeout_err_d;
  logic              stall_inc;
  logic              flush_inc;
  logic              run_rules;
  logic              load_use;

  fwd_unit #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_fwd_unit (
    .ex_rs1       (ex_rs1),
    .ex_rs2       (ex_rs2),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .mem_rd       (mem_rd),
    .wb_rd        (wb_rd),
    .mem_reg_write(mem_reg_write),
    .wb_reg_write (wb_reg_write),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .id_byp_a     (id_byp_a),
    .id_byp_b     (id_byp_b)
  );

  // Load in EX whose result the ID instruction needs; x0 never creates a hazard.
  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((id_rs1_used && (id_rs1 == ex_rd)) || (id_rs2_used && (id_rs2 == ex_rd)));

  // Next state, stage controls and statistic increments.
  always_comb begin
    state_d      = state_q;
    prime_cnt_d  = prime_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    run_rules    = 1'b0;
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    idex_en      = 1'b1;
    exmem_en     = 1'b1;
    memwb_en     = 1'b1;
    ifid_setnull = 1'b0;
    idex_setnull = 1'b0;

    unique case (state_q)
      StPrime: begin
        pc_en        = 1'b0;
        ifid_en      = 1'b0;
        ifid_setnull = 1'b1;
        idex_setnull = 1'b1;
        if (prime_cnt_q == PrimeW'(PRIME_CYCLES - 1)) begin
          state_d = StRun;
        end else begin
          prime_cnt_d = prime_cnt_q + 1'b1;
        end
      end
      StRun: begin
        if (mem_busy) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_en    = 1'b0;
          exmem_en   = 1'b0;
          memwb_en   = 1'b0;
          stall_inc  = 1'b1;
          wait_cnt_d = WaitW'(1);
          state_d    = StMemWait;
        end else begin
          run_rules = 1'b1;
        end
      end
      StMemWait: begin
        if (mem_busy) begin
          pc_en     = 1'b0;
          ifid_en   = 1'b0;
          idex_en   = 1'b0;
          exmem_en  = 1'b0;
          memwb_en  = 1'b0;
          stall_inc = 1'b1;
          // Counter already holds the busy cycles before this one.
          if (wait_cnt_q >= WaitW'(WAIT_TIMEOUT - 1)) begin
            state_d = StHalt;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end else begin
          // Memory ready: resume and apply normal rules this same cycle.
          state_d   = StRun;
          run_rules = 1'b1;
        end
      end
      StHalt: begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        exmem_en = 1'b0;
        memwb_en = 1'b0;
      end
      default: state_d = StPrime;
    endcase

    // A taken branch squashes the wrong-path ID instruction, so any load-use is moot.
    if (run_rules) begin
      if (branch_taken) begin
        ifid_setnull = 1'b1;
        idex_setnull = 1'b1;
        flush_inc    = 1'b1;
      end else if (load_use) begin
        pc_en        = 1'b0;
        ifid_en      = 1'b0;
        idex_setnull = 1'b1;
        stall_inc    = 1'b1;
      end
    end
  end

  // Saturating statistics and sticky timeout flag.
  always_comb begin
    stall_cnt_d   = stall_cnt_q;
    flush_cnt_d   = flush_cnt_q;
    timeout_err_d = timeout_err_q | (state_d == StHalt);
    if (stall_inc && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (flush_inc && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  // State and counter registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= StPrime;
      prime_cnt_q   <= '0;
      wait_cnt_q    <= '0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      prime_cnt_q   <= prime_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random traffic
// compared each cycle against a cycle-count reference model.
module tb_hazard_ctrl;

  localparam int PrimeCycles = 4;
  localparam int WaitTimeout = 255;
  localparam int SatW        = 3;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic       id_rs1_used, id_rs2_used, ex_mem_read, mem_reg_write, wb_reg_write;
  logic       branch_taken, mem_busy;

  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_setnull, idex_setnull;
  logic [1:0]  fwd_a, fwd_b;
  logic        id_byp_a, id_byp_b, timeout_err;
  logic [15:0] stall_cnt, flush_cnt;

  logic            s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en;
  logic            s_ifid_setnull, s_idex_setnull;
  logic [1:0]      s_fwd_a, s_fwd_b;
  logic            s_id_byp_a, s_id_byp_b, s_timeout_err;
  logic [SatW-1:0] s_stall_cnt, s_flush_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: cycles of priming left, consecutive busy cycles, halt flag, raw event counts.
  int m_prime_left;
  int m_busy_run;
  bit m_halted;
  int m_stall;
  int m_flush;

  always #5 CLK = ~CLK;

  hazard_ctrl dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rs1_used  (id_rs1_used),
    .id_rs2_used  (id_rs2_used),
    .ex_rs1       (ex_rs1),
    .ex_rs2       (ex_rs2),
    .ex_rd        (ex_rd),
    .ex_mem_read  (ex_mem_read),
    .mem_rd       (mem_rd),
    .wb_rd        (wb_rd),
    .mem_reg_write(mem_reg_write),
    .wb_reg_write (wb_reg_write),
    .branch_taken (branch_taken),
    .mem_busy     (mem_busy),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .idex_en      (idex_en),
    .exmem_en     (exmem_en),
    .memwb_en     (memwb_en),
    .ifid_setnull (ifid_setnull),
    .idex_setnull (idex_setnull),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .id_byp_a     (id_byp_a),
    .id_byp_b     (id_byp_b),
    .timeout_err  (timeout_err),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  // Narrow-counter instance so saturation is reached within a short run.
  hazard_ctrl #(
    .CNT_W(SatW)
  ) dut_sat (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rs1_used  (id_rs1_used),
    .id_rs2_used  (id_rs2_used),
    .ex_rs1       (ex_rs1),
    .ex_rs2       (ex_rs2),
    .ex_rd        (ex_rd),
    .ex_mem_read  (ex_mem_read),
    .mem_rd       (mem_rd),
    .wb_rd        (wb_rd),
    .mem_reg_write(mem_reg_write),
    .wb_reg_write (wb_reg_write),
    .branch_taken (branch_taken),
    .mem_busy     (mem_busy),
    .pc_en        (s_pc_en),
    .ifid_en      (s_ifid_en),
    .idex_en      (s_idex_en),
    .exmem_en     (s_exmem_en),
    .memwb_en     (s_memwb_en),
    .ifid_setnull (s_ifid_setnull),
    .idex_setnull (s_idex_setnull),
    .fwd_a        (s_fwd_a),
    .fwd_b        (s_fwd_b),
    .id_byp_a     (s_id_byp_a),
    .id_byp_b     (s_id_byp_b),
    .timeout_err  (s_timeout_err),
    .stall_cnt    (s_stall_cnt),
    .flush_cnt    (s_flush_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int top;
    top = (1 << w) - 1;
    return (v > top) ? top : v;
  endfunction

  function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
    if (mem_reg_write && mem_rd != 0 && mem_rd == rs) return 2'b01;
    if (wb_reg_write && wb_rd != 0 && wb_rd == rs) return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit exp_load_use();
    return ex_mem_read && ex_rd != 0 &&
           ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
  endfunction

  task automatic model_reset();
    m_prime_left = PrimeCycles;
    m_busy_run   = 0;
    m_halted     = 1'b0;
    m_stall      = 0;
    m_flush      = 0;
  endtask

  task automatic check_outputs();
    logic [4:0] en;
    logic [1:0] sn;
    bit         wb_hit1, wb_hit2;
    if (!RST_N || m_prime_left > 0) begin
      en = 5'b00111; sn = 2'b11;
    end else if (m_halted || mem_busy) begin
      en = 5'b00000; sn = 2'b00;
    end else if (branch_taken) begin
      en = 5'b11111; sn = 2'b11;
    end else if (exp_load_use()) begin
      en = 5'b00111; sn = 2'b01;
    end else begin
      en = 5'b11111; sn = 2'b00;
    end
    wb_hit1 = wb_reg_write && wb_rd != 0 && wb_rd == id_rs1;
    wb_hit2 = wb_reg_write && wb_rd != 0 && wb_rd == id_rs2;
    check_eq("enables", 32'({pc_en, ifid_en, idex_en, exmem_en, memwb_en}), 32'(en));
    check_eq("setnull", 32'({ifid_setnull, idex_setnull}), 32'(sn));
    check_eq("fwd_a", 32'(fwd_a), 32'(exp_fwd(ex_rs1)));
    check_eq("fwd_b", 32'(fwd_b), 32'(exp_fwd(ex_rs2)));
    check_eq("id_byp", 32'({id_byp_a, id_byp_b}), 32'({wb_hit1, wb_hit2}));
    check_eq("timeout_err", 32'(timeout_err), 32'(m_halted));
    check_eq("stall_cnt", 32'(stall_cnt), 32'(sat(m_stall, 16)));
    check_eq("flush_cnt", 32'(flush_cnt), 32'(sat(m_flush, 16)));
    check_eq("sat_stall_cnt", 32'(s_stall_cnt), 32'(sat(m_stall, SatW)));
    check_eq("sat_flush_cnt", 32'(s_flush_cnt), 32'(sat(m_flush, SatW)));
  endtask

  task automatic model_advance();
    if (!RST_N) begin
      model_reset();
    end else if (m_halted) begin
      // frozen until reset
    end else if (m_prime_left > 0) begin
      m_prime_left--;
    end else if (mem_busy) begin
      m_stall++;
      m_busy_run++;
      if (m_busy_run >= WaitTimeout) m_halted = 1'b1;
    end else begin
      m_busy_run = 0;
      if (branch_taken) m_flush++;
      else if (exp_load_use()) m_stall++;
    end
  endtask

  // Inputs are set just after a falling edge; check, then clock once.
  task automatic step();
    #1;
    check_outputs();
    @(posedge CLK);
    model_advance();
    @(negedge CLK);
  endtask

  task automatic clr_inputs();
    {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
    {id_rs1_used, id_rs2_used, ex_mem_read, mem_reg_write, wb_reg_write} = '0;
    branch_taken = 1'b0;
    mem_busy     = 1'b0;
  endtask

  task automatic rand_inputs();
    id_rs1        = 5'($urandom_range(0, 3));
    id_rs2        = 5'($urandom_range(0, 3));
    ex_rs1        = 5'($urandom_range(0, 3));
    ex_rs2        = 5'($urandom_range(0, 3));
    ex_rd         = 5'($urandom_range(0, 3));
    mem_rd        = 5'($urandom_range(0, 3));
    wb_rd         = 5'($urandom_range(0, 3));
    id_rs1_used   = 1'($urandom_range(0, 1));
    id_rs2_used   = 1'($urandom_range(0, 1));
    ex_mem_read   = 1'($urandom_range(0, 1));
    mem_reg_write = 1'($urandom_range(0, 1));
    wb_reg_write  = 1'($urandom_range(0, 1));
    branch_taken  = ($urandom_range(0, 5) == 0);
    mem_busy      = ($urandom_range(0, 6) == 0);
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(negedge CLK);
    step();
    RST_N = 1'b1;
  endtask

  initial begin
    clr_inputs();
    model_reset();
    @(negedge CLK);
    do_reset();

    // Priming window then first RUN cycle.
    for (int i = 0; i < PrimeCycles; i++) begin
      check_eq("prime_pc_en", 32'(pc_en), 32'(0));
      step();
    end
    check_eq("run_pc_en", 32'(pc_en), 32'(1));
    step();

    // Load-use bubble, then MEM/WB forward on the following cycle.
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1'b1;
    step();
    check_eq("lu_stall_cnt", 32'(stall_cnt), 32'(1));
    clr_inputs();
    ex_rs1 = 5'd5; wb_rd = 5'd5; wb_reg_write = 1'b1;
    #1;
    check_eq("lu_fwd_a_wb", 32'(fwd_a), 32'(2));
    step();

    // Branch with coincident load-use: flush wins.
    clr_inputs();
    ex_mem_read = 1'b1; ex_rd = 5'd6; id_rs2 = 5'd6; id_rs2_used = 1'b1; branch_taken = 1'b1;
    step();
    check_eq("br_flush_cnt", 32'(flush_cnt), 32'(1));
    check_eq("br_stall_unchanged", 32'(stall_cnt), 32'(1));

    // Busy for 3 cycles with branch pending; flush happens on the exit cycle.
    clr_inputs();
    branch_taken = 1'b1; mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check_eq("busy_stall_cnt", 32'(stall_cnt), 32'(4));
    mem_busy = 1'b0;
    step();
    check_eq("busy_exit_flush", 32'(flush_cnt), 32'(2));

    // Forwarding priority, x0 exclusion, and ID bypass.
    clr_inputs();
    mem_rd = 5'd7; wb_rd = 5'd7; mem_reg_write = 1'b1; wb_reg_write = 1'b1; ex_rs2 = 5'd7;
    #1;
    check_eq("fwd_b_mem_wins", 32'(fwd_b), 32'(1));
    step();
    mem_rd = 5'd0; wb_rd = 5'd0; ex_rs2 = 5'd0;
    #1;
    check_eq("fwd_b_x0", 32'(fwd_b), 32'(0));
    step();
    wb_rd = 5'd3; id_rs2 = 5'd3;
    #1;
    check_eq("id_byp_b", 32'(id_byp_b), 32'(1));
    step();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      rand_inputs();
      step();
    end

    // Reset mid-operation returns to priming immediately.
    rand_inputs();
    mem_busy = 1'b0;
    #1;
    RST_N = 1'b0;
    model_reset();
    #1;
    check_eq("midrst_pc_en", 32'(pc_en), 32'(0));
    check_eq("midrst_stall", 32'(stall_cnt), 32'(0));
    @(negedge CLK);
    step();
    RST_N = 1'b1;
    for (int i = 0; i < 300; i++) begin
      rand_inputs();
      step();
    end

    // One cycle short of timeout must recover.
    clr_inputs();
    step();
    mem_busy = 1'b1;
    for (int i = 0; i < WaitTimeout - 1; i++) step();
    mem_busy = 1'b0;
    step();
    check_eq("no_timeout_254", 32'(timeout_err), 32'(0));

    // Full timeout: halt and stay halted.
    mem_busy = 1'b1;
    for (int i = 0; i < WaitTimeout; i++) step();
    check_eq("timeout_set", 32'(timeout_err), 32'(1));
    mem_busy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rand_inputs();
      step();
    end
    check_eq("timeout_sticky", 32'(timeout_err), 32'(1));

    clr_inputs();
    do_reset();
    check_eq("post_rst_timeout", 32'(timeout_err), 32'(0));
    for (int i = 0; i < 6; i++) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
